aes_block_ctrl: RTL and testbench
=================================

Name: aes_block_ctrl

Overview:
- Controller that sequences one iterative AES-128 round datapath for the 32-bit encryption interface.
- Packs four 32-bit plaintext words into a 128-bit block and loads it into the datapath.
- Issues one round-enable per cycle for NUM_ROUNDS rounds, captures the 128-bit result and serialises it as four 32-bit ciphertext words with backpressure.
- Sits between the word-stream host interface and the round datapath / key schedule.

Parameters:
- NUM_ROUNDS, 10, number of cipher rounds issued per block (10 for AES-128).
- WORD_W, 32, width of host input and output words.
- WORDS_PER_BLK, 4, words per 128-bit block.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; one clock domain; reset is synchronous and active-high
- plaintextEnable  input  1  host word valid
- plaintext  input  32  host plaintext word
- in_ready  output  1  controller accepts a word this cycle
- err_drop  output  1  one-cycle pulse when plaintextEnable=1 while in_ready=0 (word discarded)
- busy  output  1  high from the first accepted word until the last output word handshake
- dp_load  output  1  one-cycle pulse: datapath loads dp_block and applies the initial AddRoundKey
- dp_block  output  128  assembled plaintext block; word0 occupies [127:96]
- dp_round_en  output  1  datapath performs one round this cycle
- dp_round_idx  output  4  round number 1..NUM_ROUNDS; 0 when idle
- dp_final_round  output  1  high with dp_round_en on round NUM_ROUNDS (MixColumns skipped)
- dp_state  input  128  datapath state register; valid the cycle after the final round_en
- out_ready  input  1  sink accepts a ciphertext word
- ciphertextDone  output  1  ciphertext word valid
- ciphertext  output  32  ciphertext word; word0 is [127:96] of the result

Behaviour:
- Reset: synchronous; takes effect at the clk edge while rst=1.
  - All outputs and internal registers go to 0; state goes to IDLE.
  - Reset mid-block aborts the block. No partial output is emitted.
- States and transitions:
  - IDLE to COLLECT on the first accepted word.
  - COLLECT to LOAD when the WORDS_PER_BLK-th word is accepted.
  - LOAD to ROUND, after 1 cycle.
  - ROUND to CAPTURE after the round with idx NUM_ROUNDS.
  - CAPTURE to DRAIN, after 1 cycle.
  - DRAIN to IDLE after the last word handshake.
- Input handshake: in_ready=1 only in IDLE and COLLECT. A word is accepted when plaintextEnable && in_ready. Word k goes to dp_block[127-32k -: 32]. The word counter wraps to 0 after the 4th word.
- LOAD: dp_load=1 for exactly 1 cycle. dp_block is stable from LOAD until the next block's first accept.
- ROUND: dp_round_en=1 for NUM_ROUNDS consecutive cycles, with dp_round_idx=1,2,..,NUM_ROUNDS. dp_final_round=1 only when idx==NUM_ROUNDS. dp_round_idx returns to 0 when the state leaves ROUND.
- CAPTURE: latch dp_state into a 128-bit output buffer.
- DRAIN:
  - ciphertextDone=1 with the current word.
  - Word and valid hold stable while out_ready=0.
  - The pointer advances on ciphertextDone && out_ready.
  - The 4th handshake goes to IDLE next cycle with ciphertextDone=0.
- Latency: 4th word accepted at cycle T.
  - dp_load at T+1.
  - Rounds at T+2..T+1+NUM_ROUNDS.
  - Capture at T+2+NUM_ROUNDS.
  - First ciphertextDone at T+3+NUM_ROUNDS, i.e. T+13 for 10 rounds.
- Simultaneous events: plaintextEnable during LOAD, ROUND, CAPTURE or DRAIN is dropped and err_drop pulses, including on the same cycle as the final output handshake. No overlap of blocks.
- busy=0 only in IDLE.
- Arithmetic: the round counter is 4 bits; NUM_ROUNDS must be ≤15, checked by elaboration assertion.

Decomposition:
- aes_pkg holds:
  - the ctrl_state_t enum (IDLE, COLLECT, LOAD, ROUND, CAPTURE, DRAIN);
  - AES_NR128=10 and BLK_W=128;
  - the word-index helper constants.
- One sub-module, aes_out_serializer: 128-bit buffer, 2-bit pointer, valid/ready output stage, done pulse back to the FSM.

Test Plan:
- FIPS-197 App. B input 3243f6a8, 885a308d, 313198a2, e0370734 on consecutive cycles → dp_block=3243f6a8885a308d313198a2e0370734; dp_load at T+1; round_idx 1..10 at T+2..T+11; dp_final_round only at T+11.
- Datapath stub drives dp_state=3925841d02dc09fbdc118597196a0b32; out_ready=1 → ciphertext 3925841d, 02dc09fb, dc118597, 196a0b32 at T+13..T+16; busy falls at T+17.
- Words with gaps (plaintextEnable low 3 cycles between words) → same dp_block; latency counted from the 4th accept.
- out_ready toggling 1,0,0,1,… during DRAIN → each word held stable while stalled; exactly 4 handshakes; no duplicates.
- plaintextEnable=1 during ROUND with value deadbeef → err_drop pulses once per cycle; dp_block unchanged; next block assembles correctly.
- rst=1 for one cycle at round 5 → next cycle all outputs 0, state IDLE; a fresh 4-word block then completes with normal latency.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 block controller.
// Holds the controller state enum, block/word sizes and word-slot helpers.
package aes_pkg;

    localparam int AES_NR128         = 10;
    localparam int BLK_W             = 128;
    localparam int AES_WORD_W        = 32;
    localparam int AES_WORDS_PER_BLK = 4;
    localparam int WIDX_W            = 2;

    localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(AES_WORDS_PER_BLK - 1);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        LOAD,
        ROUND,
        CAPTURE,
        DRAIN
    } ctrl_state_t;

    // Word 0 sits in the most significant slot of the block.
    function automatic int word_lsb(input logic [WIDX_W-1:0] k);
        return BLK_W - AES_WORD_W * (int'(k) + 1);
    endfunction

endpackage

// File: rtl/aes_out_serializer.sv
// Ciphertext output stage: buffers a 128-bit result, emits it as four words.
// Ports: clk, rst, load_i/data_i (capture), out_ready_i, valid_o, word_o, done_o.
module aes_out_serializer
    import aes_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [BLK_W-1:0]      data_i,
    input  logic                  out_ready_i,
    output logic                  valid_o,
    output logic [AES_WORD_W-1:0] word_o,
    output logic                  done_o
);

    logic [BLK_W-1:0]  obuf_q;
    logic [WIDX_W-1:0] ptr_q;
    logic              valid_q;
    logic              hs;

    assign hs = valid_q && out_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            obuf_q  <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            obuf_q  <= data_i;
            ptr_q   <= '0;
            valid_q <= 1'b1;
        end else if (hs) begin
            ptr_q <= ptr_q + 1'b1;
            if (ptr_q == WIDX_LAST) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign valid_o = valid_q;
    assign word_o  = obuf_q[word_lsb(ptr_q) +: AES_WORD_W];
    // Tells the FSM the last word left this cycle.
    assign done_o  = hs && (ptr_q == WIDX_LAST);

endmodule

// File: rtl/aes_block_ctrl.sv
// Sequencer for an iterative AES-128 round datapath on a 32-bit word stream.
// Ports: host in (plaintext*), datapath (dp_*), host out (ciphertext*), status.
module aes_block_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS    = AES_NR128,
    parameter int WORD_W        = AES_WORD_W,
    parameter int WORDS_PER_BLK = AES_WORDS_PER_BLK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              plaintextEnable,
    input  logic [WORD_W-1:0] plaintext,
    output logic              in_ready,
    output logic              err_drop,
    output logic              busy,
    output logic              dp_load,
    output logic [BLK_W-1:0]  dp_block,
    output logic              dp_round_en,
    output logic [3:0]        dp_round_idx,
    output logic              dp_final_round,
    input  logic [BLK_W-1:0]  dp_state,
    input  logic              out_ready,
    output logic              ciphertextDone,
    output logic [WORD_W-1:0] ciphertext
);

    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 15) begin : g_nr_chk
        $error("NUM_ROUNDS must fit the 4-bit round counter (1..15)");
    end

    if (WORD_W != AES_WORD_W || WORDS_PER_BLK != AES_WORDS_PER_BLK)
    begin : g_geom_chk
        $error("block geometry must be 4 x 32-bit words");
    end

    localparam logic [3:0] NR4 = 4'(NUM_ROUNDS);

    ctrl_state_t       state_q;
    logic [WIDX_W-1:0] wcnt_q;
    logic [BLK_W-1:0]  blk_q;
    logic              load_q;
    logic              ren_q;
    logic [3:0]        ridx_q;
    logic              final_q;
    logic              collecting;
    logic              accept;
    logic              ser_done;

    assign collecting = (state_q == IDLE) || (state_q == COLLECT);
    assign in_ready   = !rst && collecting;
    assign accept     = plaintextEnable && in_ready;
    assign err_drop   = !rst && plaintextEnable && !collecting;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            blk_q   <= '0;
            load_q  <= 1'b0;
            ren_q   <= 1'b0;
            ridx_q  <= '0;
            final_q <= 1'b0;
        end else begin
            load_q <= 1'b0;
            unique case (state_q)
                IDLE, COLLECT: begin
                    if (accept) begin
                        blk_q[word_lsb(wcnt_q) +: AES_WORD_W] <= plaintext;
                        wcnt_q <= wcnt_q + 1'b1;
                        if (wcnt_q == WIDX_LAST) begin
                            state_q <= LOAD;
                            load_q  <= 1'b1;
                        end else begin
                            state_q <= COLLECT;
                        end
                    end
                end
                LOAD: begin
                    state_q <= ROUND;
                    ren_q   <= 1'b1;
                    ridx_q  <= 4'd1;
                    final_q <= (NR4 == 4'd1);
                end
                ROUND: begin
                    if (ridx_q == NR4) begin
                        state_q <= CAPTURE;
                        ren_q   <= 1'b0;
                        ridx_q  <= '0;
                        final_q <= 1'b0;
                    end else begin
                        ridx_q  <= ridx_q + 4'd1;
                        final_q <= (ridx_q + 4'd1 == NR4);
                    end
                end
                CAPTURE: begin
                    state_q <= DRAIN;
                end
                DRAIN: begin
                    if (ser_done) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // dp_state is valid in CAPTURE, the cycle after the final round.
    aes_out_serializer u_ser (
        .clk         (clk),
        .rst         (rst),
        .load_i      (state_q == CAPTURE),
        .data_i      (dp_state),
        .out_ready_i (out_ready),
        .valid_o     (ciphertextDone),
        .word_o      (ciphertext),
        .done_o      (ser_done)
    );

    assign busy           = (state_q != IDLE);
    assign dp_load        = load_q;
    assign dp_block       = blk_q;
    assign dp_round_en    = ren_q;
    assign dp_round_idx   = ridx_q;
    assign dp_final_round = final_q;

endmodule

// File: tb/tb_aes_block_ctrl.sv
// Randomised scoreboard bench for aes_block_ctrl with a toy round datapath.
// Expected ciphertext words are queued at issue; a monitor checks each cycle.
module tb_aes_block_ctrl;

    localparam int NR = 10;
    localparam logic [127:0] FIPS_PT = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_CT = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY     = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic         clk;
    logic         rst;
    logic         plaintextEnable;
    logic [31:0]  plaintext;
    logic         in_ready;
    logic         err_drop;
    logic         busy;
    logic         dp_load;
    logic [127:0] dp_block;
    logic         dp_round_en;
    logic [3:0]   dp_round_idx;
    logic         dp_final_round;
    logic [127:0] dp_state;
    logic         out_ready;
    logic         ciphertextDone;
    logic [31:0]  ciphertext;

    aes_block_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .plaintextEnable (plaintextEnable),
        .plaintext       (plaintext),
        .in_ready        (in_ready),
        .err_drop        (err_drop),
        .busy            (busy),
        .dp_load         (dp_load),
        .dp_block        (dp_block),
        .dp_round_en     (dp_round_en),
        .dp_round_idx    (dp_round_idx),
        .dp_final_round  (dp_final_round),
        .dp_state        (dp_state),
        .out_ready       (out_ready),
        .ciphertextDone  (ciphertextDone),
        .ciphertext      (ciphertext)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Toy round datapath: rotate-left-1 then xor the round number.
    logic [127:0] st;
    logic [127:0] ld;
    always @(posedge clk) begin
        if (rst) begin
            st <= '0;
            ld <= '0;
        end else if (dp_load) begin
            ld <= dp_block;
            st <= dp_block ^ KEY;
        end else if (dp_round_en) begin
            if (dp_final_round && ld == FIPS_PT) st <= FIPS_CT;
            else st <= {st[126:0], st[127]} ^ {32{dp_round_idx}};
        end
    end
    assign dp_state = st;

    function automatic logic [127:0] ref_cipher(input logic [127:0] b);
        logic [127:0] s;
        if (b == FIPS_PT) return FIPS_CT;
        s = b ^ KEY;
        for (int r = 1; r <= NR; r++) s = {s[126:0], s[127]} ^ {32{4'(r)}};
        return s;
    endfunction

    logic [31:0] exp_ct_q[$];

    // Monitor: reference behaviour derived from latency rules.
    logic [127:0] asm_blk;
    logic [127:0] cur_blk;
    int  widx = 0;
    int  t4 = -100;
    int  out_cnt = 0;
    bit  blk_active = 0;
    bit  chk_rst = 0;
    bit  acc;
    bit  e_ren;
    int  e_idx;

    always @(negedge clk) begin
        if (rst) begin
            widx = 0;
            blk_active = 0;
            out_cnt = 0;
            exp_ct_q.delete();
            chk_rst = 1;
        end else begin
            if (chk_rst) begin
                chk("rst_load", dp_load, 0);
                chk("rst_round_en", dp_round_en, 0);
                chk("rst_round_idx", dp_round_idx, 0);
                chk("rst_final", dp_final_round, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", ciphertextDone, 0);
                chk("rst_ct", ciphertext, 0);
                chk("rst_block", dp_block, 0);
                chk("rst_in_ready", in_ready, 1);
                chk_rst = 0;
            end
            acc   = plaintextEnable && !blk_active;
            e_ren = blk_active && cyc >= t4 + 2 && cyc <= t4 + 1 + NR;
            e_idx = e_ren ? cyc - t4 - 1 : 0;
            chk("in_ready", in_ready, !blk_active);
            chk("err_drop", err_drop, plaintextEnable && blk_active);
            chk("busy", busy, blk_active || widx != 0);
            chk("dp_load", dp_load, blk_active && cyc == t4 + 1);
            chk("round_en", dp_round_en, e_ren);
            chk("round_idx", dp_round_idx, e_idx);
            chk("final_round", dp_final_round, e_ren && e_idx == NR);
            chk("ct_valid", ciphertextDone, blk_active && cyc >= t4 + 3 + NR);
            if (blk_active) chk("dp_block", dp_block, cur_blk);
            if (ciphertextDone) begin
                if (exp_ct_q.size() == 0) begin
                    chk("ct_unexpected", ciphertextDone, 0);
                end else begin
                    chk("ciphertext", ciphertext, exp_ct_q[0]);
                    if (out_ready) begin
                        void'(exp_ct_q.pop_front());
                        out_cnt++;
                        if (out_cnt == 4) begin
                            blk_active = 0;
                            out_cnt = 0;
                        end
                    end
                end
            end
            if (acc) begin
                asm_blk[127 - 32 * widx -: 32] = plaintext;
                widx++;
                if (widx == 4) begin
                    cur_blk = asm_blk;
                    t4 = cyc;
                    blk_active = 1;
                    widx = 0;
                end
            end
        end
    end

    int rdy_mode = 0;
    int rdy_k = 0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rdy_k++;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = (rdy_k % 3 == 0);
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    bit junk = 0;

    task automatic send_word(input logic [31:0] w);
        bit got;
        got = 0;
        plaintextEnable = 1'b1;
        plaintext = w;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
        end
        plaintextEnable = 1'b0;
        if (!got) chk("accept_timeout", got, 1);
    endtask

    task automatic send_block(input logic [127:0] b, input int gap);
        logic [127:0] c;
        c = ref_cipher(b);
        for (int k = 0; k < 4; k++) exp_ct_q.push_back(c[127 - 32 * k -: 32]);
        for (int k = 0; k < 4; k++) begin
            send_word(b[127 - 32 * k -: 32]);
            if (k < 3) repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            plaintextEnable = junk && !in_ready && ($urandom_range(0, 1) == 1);
            plaintext = $urandom;
            if (!busy && exp_ct_q.size() == 0) begin
                plaintextEnable = 1'b0;
                return;
            end
        end
        plaintextEnable = 1'b0;
        chk("idle_timeout", exp_ct_q.size() + int'(busy), 0);
    endtask

    function automatic logic [127:0] rnd_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        rst = 1'b1;
        plaintextEnable = 1'b0;
        plaintext = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        send_block(FIPS_PT, 0);
        wait_idle();

        send_block(FIPS_PT, 3);
        wait_idle();

        rdy_mode = 1;
        send_block(rnd_blk(), 0);
        wait_idle();
        rdy_mode = 0;

        send_block(rnd_blk(), 1);
        begin
            int n;
            n = 0;
            for (int i = 0; i < 40 && n < 3; i++) begin
                @(posedge clk);
                #1;
                if (dp_round_en) begin
                    plaintextEnable = 1'b1;
                    plaintext = 32'hdeadbeef;
                    n++;
                end else begin
                    plaintextEnable = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            plaintextEnable = 1'b0;
        end
        wait_idle();
        send_block(rnd_blk(), 0);
        wait_idle();

        send_block(rnd_blk(), 0);
        begin
            bit hit;
            hit = 0;
            for (int i = 0; i < 40 && !hit; i++) begin
                @(posedge clk);
                #1;
                hit = (dp_round_idx == 4'd5);
            end
            if (!hit) chk("round5_timeout", hit, 1);
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
        end
        send_block(FIPS_PT, 0);
        wait_idle();

        rdy_mode = 2;
        junk = 1;
        repeat (8) send_block(rnd_blk(), $urandom_range(0, 2));
        wait_idle();
        junk = 0;

        repeat (3) @(posedge clk);
        chk("ct_leftover", exp_ct_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
